// File: rtl/pipelined_cla_adder.sv
// Purpose: parametrised add/subtract unit, one operand slice summed per pipeline stage with grouped carry-lookahead.
// Latency: SEGMENTS cycles from acceptance to out_valid; one result per cycle sustained.
// Backpressure: out_valid & ~out_ready freezes every stage; in_ready mirrors the pipeline enable combinationally.
module pipelined_cla_adder #(
  parameter int WIDTH    = 32,
  parameter int SEGMENTS = 4,
  parameter int GROUP    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int SEG_W = WIDTH / SEGMENTS;

  // Reject geometries that cannot be cut into equal slices of whole lookahead groups.
  if (SEGMENTS < 1 || SEGMENTS > 8 || GROUP < 1 ||
      WIDTH != SEGMENTS * SEG_W || (SEG_W % GROUP) != 0) begin : g_param_check
    $error("pipelined_cla_adder: illegal WIDTH/SEGMENTS/GROUP combination");
  end

  // Slice adder: full lookahead inside each GROUP-bit group, group carries
  // ripple from one group to the next. Returns {carry_out, sum}.
  function automatic logic [SEG_W:0] cla_slice(input logic [SEG_W-1:0] x,
                                               input logic [SEG_W-1:0] y,
                                               input logic             ci);
    logic [SEG_W-1:0] p;
    logic [SEG_W-1:0] g;
    logic [SEG_W-1:0] s;
    logic             gc;
    logic             c;
    logic             term;
    int               base;
    p  = x ^ y;
    g  = x & y;
    s  = '0;
    gc = ci;
    for (int grp = 0; grp < SEG_W / GROUP; grp++) begin
      base = grp * GROUP;
      // i == GROUP yields the group carry-out from the same lookahead form
      for (int i = 0; i <= GROUP; i++) begin
        c = gc;
        for (int j = 0; j < i; j++) c = c & p[base+j];
        for (int j = 0; j < i; j++) begin
          term = g[base+j];
          for (int m = j + 1; m < i; m++) term = term & p[base+m];
          c = c | term;
        end
        if (i < GROUP) s[base+i] = p[base+i] ^ c;
        else           gc = c;
      end
    end
    return {gc, s};
  endfunction

  logic             en;
  logic [WIDTH-1:0] beff;
  logic             c0;

  assign en       = ~out_valid | out_ready;
  assign in_ready = en;
  assign beff     = b ^ {WIDTH{sub}};
  assign c0       = sub | cin;

  for (genvar k = 0; k < SEGMENTS; k++) begin : g_stage
    // Operand bits still to be summed when the wavefront reaches this stage.
    localparam int RW = WIDTH - k * SEG_W;

    logic [RW-1:0]  a_in;
    logic [RW-1:0]  b_in;
    logic           c_in;
    logic           v_in;
    logic [SEG_W:0] res;

    if (k == 0) begin : g_src
      assign a_in = a;
      assign b_in = beff;
      assign c_in = c0;
      assign v_in = in_valid;
    end else begin : g_src
      assign a_in = g_stage[k-1].g_reg.a_q;
      assign b_in = g_stage[k-1].g_reg.b_q;
      assign c_in = g_stage[k-1].g_reg.c_q;
      assign v_in = g_stage[k-1].g_reg.v_q;
    end

    assign res = cla_slice(a_in[SEG_W-1:0], b_in[SEG_W-1:0], c_in);

    if (k < SEGMENTS - 1) begin : g_reg
      logic [RW-SEG_W-1:0]     a_q;
      logic [RW-SEG_W-1:0]     b_q;
      logic [(k+1)*SEG_W-1:0]  s_q;
      logic [(k+1)*SEG_W-1:0]  s_nxt;
      logic                    c_q;
      logic                    v_q;

      if (k == 0) begin : g_cat
        assign s_nxt = res[SEG_W-1:0];
      end else begin : g_cat
        assign s_nxt = {res[SEG_W-1:0], g_stage[k-1].g_reg.s_q};
      end

      // Stage register: carry and finished low slices advance, unsummed high slices skew along.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q <= 1'b0;
          c_q <= 1'b0;
          s_q <= '0;
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          v_q <= v_in;
          c_q <= res[SEG_W];
          s_q <= s_nxt;
          a_q <= a_in[RW-1:SEG_W];
          b_q <= b_in[RW-1:SEG_W];
        end
      end
    end else begin : g_out
      logic [WIDTH-1:0] s_nxt;

      if (k == 0) begin : g_cat
        assign s_nxt = res[SEG_W-1:0];
      end else begin : g_cat
        assign s_nxt = {res[SEG_W-1:0], g_stage[k-1].g_reg.s_q};
      end

      // Output stage: top slice completes the sum; flags are registered alongside it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid <= 1'b0;
          sum       <= '0;
          cout      <= 1'b0;
          overflow  <= 1'b0;
          zero      <= 1'b0;
          negative  <= 1'b0;
        end else if (en) begin
          out_valid <= v_in;
          sum       <= s_nxt;
          cout      <= res[SEG_W];
          overflow  <= ~(a_in[SEG_W-1] ^ b_in[SEG_W-1]) & (res[SEG_W-1] ^ a_in[SEG_W-1]);
          zero      <= (s_nxt == '0);
          negative  <= res[SEG_W-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Purpose: scoreboard bench for pipelined_cla_adder (WIDTH=32, SEGMENTS=4, GROUP=4).
// Latency: expects results SEGMENTS cycles after acceptance when the sink never stalls.
// Backpressure: drops out_ready mid-stream and checks in_ready and output hold behaviour.
module tb_pipelined_cla_adder;

  localparam int W = 32;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;
  logic         zero;
  logic         negative;

  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           popped = 0;
  int           p0;
  int           push_cyc;
  bit           lat_chk = 1'b0;
  bit           hold_pend = 1'b0;
  logic [W+3:0] held;
  logic [W+3:0] exp_v;
  logic [W+3:0] exp_q[$];
  int           cyc_q[$];
  logic [W-1:0] ra;
  logic [W-1:0] rb;
  logic         rc;
  logic         rs;

  pipelined_cla_adder #(.WIDTH(W), .SEGMENTS(S), .GROUP(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow),
    .zero      (zero),
    .negative  (negative)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference result packed as {cout, overflow, zero, negative, sum}.
  function automatic logic [W+3:0] model(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                         input logic xc, input logic xs);
    logic [W-1:0] be;
    logic [W:0]   r;
    logic         ov;
    be = xb ^ {W{xs}};
    r  = {1'b0, xa} + {1'b0, be} + {{W{1'b0}}, (xs | xc)};
    ov = ~(xa[W-1] ^ be[W-1]) & (r[W-1] ^ xa[W-1]);
    return {r[W], ov, (r[W-1:0] == '0), r[W-1], r[W-1:0]};
  endfunction

  // Present one operation; expectation is queued at the cycle it is accepted.
  task automatic send(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                      input logic xs, input logic [W+3:0] e);
    bit done = 1'b0;
    a = xa; b = xb; cin = xc; sub = xs; in_valid = 1'b1;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        cyc_q.push_back(cyc);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) chk("send_timeout", {63'd0, done}, 64'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    chk("drain", exp_q.size(), 0);
  endtask

  // Output monitor: pops the scoreboard on every output transfer, checks hold while stalled.
  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_pend && out_valid) chk("hold", {cout, overflow, zero, negative, sum}, held);
      hold_pend = 1'b0;
      if (out_valid && !out_ready) begin
        hold_pend = 1'b1;
        held      = {cout, overflow, zero, negative, sum};
        chk("in_ready_stall", in_ready, 0);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", out_valid, 0);
        end else begin
          exp_v    = exp_q.pop_front();
          push_cyc = cyc_q.pop_front();
          popped++;
          chk("result", {cout, overflow, zero, negative, sum}, exp_v);
          if (lat_chk) chk("latency", cyc - push_cyc, S);
        end
      end
    end else begin
      hold_pend = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_flags", {cout, overflow, zero, negative}, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("in_ready_after_reset", in_ready, 1);

    // Directed vectors, back-to-back, expectations written out by hand.
    lat_chk = 1'b1;
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {4'b0101, 32'h8000_0000});
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {4'b1010, 32'h0000_0000});
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, {4'b1000, 32'h0000_0001});
    send(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, {4'b0001, 32'hFFFF_FFFE});
    send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, {4'b1100, 32'h7FFF_FFFF});
    send(32'h0FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {4'b0000, 32'h1000_0000});
    send(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, {4'b1010, 32'h0000_0000});
    drain();

    // Random back-to-back stream with a three-cycle sink stall in the middle.
    lat_chk = 1'b0;
    p0 = popped;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          ra = $urandom(); rb = $urandom();
          rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
          send(ra, rb, rc, rs, model(ra, rb, rc, rs));
        end
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("stream_count", popped - p0, 8);

    // Reset with three operations in flight, then a fresh op must see clean state.
    lat_chk = 1'b1;
    send(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, model(32'h10, 32'h20, 1'b0, 1'b0));
    send(32'hFFFF_0000, 32'h0001_0000, 1'b0, 1'b0, model(32'hFFFF_0000, 32'h0001_0000, 1'b0, 1'b0));
    send(32'h0000_0009, 32'h0000_0003, 1'b0, 1'b1, model(32'h9, 32'h3, 1'b0, 1'b1));
    #1 rst_n = 1'b0;
    exp_q.delete();
    cyc_q.delete();
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_sum", sum, 0);
    chk("midrst_flags", {cout, overflow, zero, negative}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("in_ready_after_midrst", in_ready, 1);
    p0 = popped;
    send(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, {4'b0000, 32'h0000_0003});
    drain();
    repeat (6) @(posedge clk);
    chk("post_reset_count", popped - p0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
